// File: rtl/tartaruga_pkg.sv
// Shared types and constants for the instruction-memory path.
package tartaruga_pkg;

  typedef logic [31:0] bus32_t;

  // Number of 32-bit words in the instruction memory.
  localparam int unsigned IMEM_POS   = 1024;
  localparam int unsigned IMEM_IDX_W = $clog2(IMEM_POS);

  // Fetch sequencing states of the arbiter.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_PEND  = 2'd1,
    RSP_HOLD = 2'd2
  } imem_arb_state_t;

  // Held fetch response.
  typedef struct packed {
    bus32_t data;
    logic   err;
  } imem_rsp_t;

endpackage

// File: rtl/imem_addr_check.sv
// Byte address to word index conversion with alignment and range check.
module imem_addr_check
  import tartaruga_pkg::*;
(
  input  bus32_t                addr_i,
  output logic [IMEM_IDX_W-1:0] idx_o,
  output logic                  valid_o
);

  logic [31:0] w_word;

  assign w_word  = {2'b00, addr_i[31:2]};
  assign idx_o   = addr_i[IMEM_IDX_W+1:2];
  assign valid_o = (addr_i[1:0] == 2'b00) && (w_word < 32'(IMEM_POS));

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single-port IMEM between fetch reads and loader writes.
// Fetch reads run through IDLE -> RD_PEND -> RSP_HOLD with one read in
// flight; loader writes complete in their acceptance cycle and win ties
// in IDLE until fetch has waited STARVE_LIMIT loader grants in a row.
// Optional feature: define IMEM_LOADER_EN to enable the loader port.
//
// Handshakes: a transfer happens on a rising clock edge where both valid
// and ready are high; valid never depends on ready, and a held response
// keeps data/err stable until the transfer happens.
module imem_arbiter
  import tartaruga_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fetch_req_valid_i,
  output logic                  fetch_req_ready_o,
  input  bus32_t                fetch_addr_i,
  output logic                  fetch_rsp_valid_o,
  input  logic                  fetch_rsp_ready_i,
  output bus32_t                fetch_rsp_data_o,
  output logic                  fetch_rsp_err_o,
  input  logic                  load_valid_i,
  output logic                  load_ready_o,
  input  bus32_t                load_addr_i,
  input  bus32_t                load_data_i,
  output logic                  load_err_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [IMEM_IDX_W-1:0] mem_idx_o,
  output bus32_t                mem_wdata_o,
  input  bus32_t                mem_rdata_i,
  output imem_arb_state_t       dbg_state_o
);

  imem_arb_state_t       r_state;
  imem_rsp_t             r_rsp;
  logic                  r_rsp_valid;
  logic [IMEM_IDX_W-1:0] w_fetch_idx;
  logic [IMEM_IDX_W-1:0] w_load_idx;
  logic                  w_fetch_ok;
  logic                  w_load_ok;
  logic                  w_fetch_acc;
  logic                  w_load_acc;
  logic                  w_idle;

  imem_addr_check u_fetch_chk (
    .addr_i  (fetch_addr_i),
    .idx_o   (w_fetch_idx),
    .valid_o (w_fetch_ok)
  );

  imem_addr_check u_load_chk (
    .addr_i  (load_addr_i),
    .idx_o   (w_load_idx),
    .valid_o (w_load_ok)
  );

  assign w_idle      = (r_state == IDLE);
  assign w_fetch_acc = fetch_req_valid_i && fetch_req_ready_o;

`ifdef IMEM_LOADER_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_starve_cnt;
  logic       r_load_err;
  logic       w_at_limit;

  assign w_at_limit = (r_starve_cnt == LIMIT);

  // Fetch only wins IDLE when the loader is quiet or fetch has starved.
  assign fetch_req_ready_o = !rst_i && w_idle && (!load_valid_i || w_at_limit);
  // The port is free for the loader in every cycle fetch is not granted.
  assign load_ready_o      = !rst_i && (!w_idle || !(fetch_req_valid_i && w_at_limit));
  assign w_load_acc        = load_valid_i && load_ready_o;
  assign load_err_o        = r_load_err;

  // Count loader wins while fetch waits in IDLE; any fetch grant clears.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_starve_cnt <= '0;
    end else if (w_fetch_acc) begin
      r_starve_cnt <= '0;
    end else if (w_idle && fetch_req_valid_i && load_valid_i && (r_starve_cnt != 4'hF)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Sticky flag for loader writes dropped on a bad address.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_load_err <= 1'b0;
    end else if (w_load_acc && !w_load_ok) begin
      r_load_err <= 1'b1;
    end
  end
`else
  logic w_unused_load;

  assign fetch_req_ready_o = !rst_i && w_idle;
  assign load_ready_o      = 1'b0;
  assign w_load_acc        = 1'b0;
  assign load_err_o        = 1'b0;
  assign w_unused_load     = ^{load_valid_i, load_addr_i, w_load_idx, w_load_ok,
                               4'(STARVE_LIMIT)};
`endif

  // Memory port mux: fetch read on a valid grant, else an accepted write.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_idx_o   = '0;
    mem_wdata_o = '0;
    if (!rst_i) begin
      if (w_fetch_acc && w_fetch_ok) begin
        mem_req_o = 1'b1;
        mem_idx_o = w_fetch_idx;
      end else if (w_load_acc && w_load_ok) begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_idx_o   = w_load_idx;
        mem_wdata_o = load_data_i;
      end
    end
  end

  // Fetch sequencing FSM with registered response outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_rsp       <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fetch_acc) begin
            if (w_fetch_ok) begin
              r_state <= RD_PEND;
            end else begin
              r_rsp.data  <= '0;
              r_rsp.err   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= RSP_HOLD;
            end
          end
        end
        RD_PEND: begin
          // Read data is from the read cycle, so later writes cannot leak in.
          r_rsp.data  <= mem_rdata_i;
          r_rsp.err   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= RSP_HOLD;
        end
        RSP_HOLD: begin
          if (fetch_rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign fetch_rsp_valid_o = r_rsp_valid;
  assign fetch_rsp_data_o  = r_rsp.data;
  assign fetch_rsp_err_o   = r_rsp.err;
  assign dbg_state_o       = r_state;

endmodule
